// File: rtl/detect_clap_clap_pkg.sv
// detect_clap_clap_pkg: shared state encodings and default loudness threshold
package detect_clap_clap_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FIRST   = 3'd1,
    GAP     = 3'd2,
    SECOND  = 3'd3,
    DETECT  = 3'd4,
    LOCKOUT = 3'd5
  } state_t;
  localparam int unsigned DEFAULT_THRESHOLD = 1000;
endpackage

// File: rtl/detect_clap_clap_frame_counter.sv
// detect_clap_clap_frame_counter: saturating frame counter; clr with inc loads 1
module detect_clap_clap_frame_counter #(
  parameter int unsigned MAX = 3,
  parameter int unsigned W = $clog2(MAX + 2)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clock)
    if (reset) count <= '0;
    else if (clr) count <= inc ? W'(1) : '0;
    else if (inc && count != W'(MAX)) count <= count + 1'b1;
endmodule

// File: rtl/detect_clap_clap.sv
// detect_clap_clap: loud-quiet-loud energy frame detector driving a toggling light and a detect pulse
module detect_clap_clap
  import detect_clap_clap_pkg::*;
#(
  parameter int unsigned ENERGY_WIDTH    = 32,
  parameter int unsigned THRESHOLD       = DEFAULT_THRESHOLD,
  parameter int unsigned MAX_CLAP_FRAMES = 3,
  parameter int unsigned MIN_GAP         = 2,
  parameter int unsigned MAX_GAP         = 8,
  parameter int unsigned HOLDOFF         = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ENERGY_WIDTH-1:0] energy_data,
  input  logic                    energy_valid,
  output logic                    energy_ready,
  output logic                    light,
  output logic                    detect_pulse,
  output logic [2:0]              state_dbg
);
  localparam int CW = $clog2(MAX_CLAP_FRAMES + 2);
  localparam int GW = $clog2(MAX_GAP + 2);
  localparam int HW = $clog2(HOLDOFF + 2);
  state_t state;
  logic [CW-1:0] clap_cnt;
  logic [GW-1:0] gap_cnt;
  logic [HW-1:0] hold_cnt;
  logic xfer, loud, quiet;
  logic clap_clr, clap_inc, gap_clr, gap_inc, hold_clr, hold_inc;
  assign energy_ready = 1'b1;
  assign state_dbg = state;
  assign xfer = energy_valid;
  assign loud = xfer && energy_data > ENERGY_WIDTH'(THRESHOLD);
  assign quiet = xfer && !loud;
  assign clap_clr = state == IDLE || state == GAP;
  assign clap_inc = loud && state inside {IDLE, FIRST, GAP, SECOND};
  assign gap_clr = state != GAP;
  assign gap_inc = quiet && (state == FIRST || state == GAP);
  assign hold_clr = state != LOCKOUT || loud;
  assign hold_inc = quiet && state == LOCKOUT;
  detect_clap_clap_frame_counter #(.MAX(MAX_CLAP_FRAMES + 1), .W(CW)) u_clap (
    .clock(clock), .reset(reset), .clr(clap_clr), .inc(clap_inc), .count(clap_cnt)
  );
  detect_clap_clap_frame_counter #(.MAX(MAX_GAP + 1), .W(GW)) u_gap (
    .clock(clock), .reset(reset), .clr(gap_clr), .inc(gap_inc), .count(gap_cnt)
  );
  detect_clap_clap_frame_counter #(.MAX(HOLDOFF), .W(HW)) u_hold (
    .clock(clock), .reset(reset), .clr(hold_clr), .inc(hold_inc), .count(hold_cnt)
  );
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      light <= 1'b0;
      detect_pulse <= 1'b0;
    end else begin
      detect_pulse <= state == DETECT;
      if (state == DETECT) light <= ~light;
      case (state)
        IDLE:    if (loud) state <= FIRST;
        FIRST:   if (xfer) state <= quiet ? GAP : clap_cnt >= CW'(MAX_CLAP_FRAMES) ? LOCKOUT : FIRST;
        GAP:     if (xfer) state <= quiet ? (gap_cnt >= GW'(MAX_GAP) ? IDLE : GAP)
                                          : (gap_cnt >= GW'(MIN_GAP) ? SECOND : LOCKOUT);
        SECOND:  if (xfer) state <= quiet ? DETECT : clap_cnt >= CW'(MAX_CLAP_FRAMES) ? LOCKOUT : SECOND;
        DETECT:  state <= LOCKOUT;
        LOCKOUT: if (quiet && hold_cnt == HW'(HOLDOFF - 1)) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_detect_clap_clap.sv
// tb_detect_clap_clap: directed scoreboard bench for the clap-clap detector
module tb_detect_clap_clap;
  localparam logic [2:0] S_IDLE = 3'd0, S_FIRST = 3'd1, S_GAP = 3'd2, S_LOCK = 3'd5;
  typedef struct {
    int   cyc;
    logic light;
  } exp_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic energy_valid = 1'b0;
  logic [31:0] energy_data = '0;
  logic energy_ready, light, detect_pulse;
  logic [2:0] state_dbg;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic exp_light = 1'b0;
  exp_t exp_q[$];
  detect_clap_clap #(
    .ENERGY_WIDTH(32), .THRESHOLD(100), .MAX_CLAP_FRAMES(3), .MIN_GAP(2), .MAX_GAP(8), .HOLDOFF(4)
  ) dut (
    .clock(clock), .reset(reset), .energy_data(energy_data), .energy_valid(energy_valid),
    .energy_ready(energy_ready), .light(light), .detect_pulse(detect_pulse), .state_dbg(state_dbg)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  always @(negedge clock)
    if (detect_pulse !== 1'b0) begin
      chk("pulse_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_light", light, e.light);
      end
    end
  task automatic frame(input int d, input int idle = 0, input bit det = 0);
    energy_valid = 1'b1;
    energy_data = d;
    @(negedge clock);
    energy_valid = 1'b0;
    if (det) begin
      exp_light = !exp_light;
      exp_q.push_back('{cyc + 1, exp_light});
    end
    repeat (idle) @(negedge clock);
  endtask
  function automatic int rnd(input int lo, input int hi);
    return int'($urandom_range(hi, lo));
  endfunction
  task automatic drain();
    repeat (3) @(negedge clock);
    chk("pulses_drained", exp_q.size(), 0);
    chk("light", light, exp_light);
  endtask
  task automatic clap(input int lo, input int hi, input int v, input bit det);
    frame(v, rnd(lo, hi));
    frame(0, rnd(lo, hi));
    frame(0, rnd(lo, hi));
    frame(v, rnd(lo, hi));
    frame(0, 1 + rnd(lo, hi), det);
    drain();
  endtask
  task automatic quiet(input int n, input int lo = 0, input int hi = 0);
    repeat (n) frame(0, rnd(lo, hi));
  endtask
  task automatic pulse_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    exp_light = 1'b0;
    chk("rst_state", state_dbg, S_IDLE);
    chk("rst_light", light, 0);
    chk("rst_pulse", detect_pulse, 0);
  endtask
  initial begin
    energy_valid = 1'b1;
    energy_data = 500;
    repeat (3) @(negedge clock);
    chk("ready_in_reset", energy_ready, 1);
    reset = 1'b0;
    energy_valid = 1'b0;
    chk("reset_state", state_dbg, S_IDLE);
    chk("reset_light", light, 0);
    chk("reset_pulse", detect_pulse, 0);
    clap(0, 0, 500, 1);
    quiet(3);
    chk("holdoff_3", state_dbg, S_LOCK);
    quiet(1);
    chk("holdoff_4", state_dbg, S_IDLE);
    clap(0, 0, 500, 1);
    quiet(4);
    chk("idle_after_2nd", state_dbg, S_IDLE);
    frame(500); frame(0); frame(500);
    chk("short_gap_lock", state_dbg, S_LOCK);
    drain();
    quiet(4);
    frame(500); frame(500); frame(500);
    chk("three_loud_first", state_dbg, S_FIRST);
    frame(500);
    chk("four_loud_lock", state_dbg, S_LOCK);
    quiet(3);
    frame(500);
    quiet(3);
    chk("loud_restarts_hold", state_dbg, S_LOCK);
    quiet(1);
    chk("hold_release", state_dbg, S_IDLE);
    frame(500); frame(500); frame(500); frame(0); frame(0); frame(500); frame(0, 1, 1);
    drain();
    quiet(4);
    frame(500);
    quiet(8);
    chk("gap_8", state_dbg, S_GAP);
    quiet(1);
    chk("gap_timeout", state_dbg, S_IDLE);
    clap(0, 0, 100, 0);
    chk("equal_is_quiet", state_dbg, S_IDLE);
    clap(0, 0, 101, 1);
    quiet(4);
    clap(1, 5, 500, 1);
    quiet(4, 1, 5);
    chk("gapped_idle", state_dbg, S_IDLE);
    frame(500); frame(0);
    chk("in_gap", state_dbg, S_GAP);
    pulse_reset();
    clap(0, 0, 500, 1);
    chk("lock_lit", state_dbg, S_LOCK);
    pulse_reset();
    clap(0, 2, 500, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
